// File: rtl/tag_tx.sv
`default_nettype none
// ============================================================================
//  tag_tx
//  Stepped-frequency IQ tone generator: per-symbol phase schedule, sin/cos
//  LUT, amplitude scaling and an AXI-Stream style backpressured output.
//  Revision: 1.0
// ============================================================================
module tag_tx #(
  parameter int DATA_WIDTH    = 16,
  parameter int SIN_COS_WIDTH = 16,
  parameter int PHASE_WIDTH   = 24,
  parameter int NSYMB_WIDTH   = 16,
  parameter int NSYMB         = 256,
  parameter int NSIG          = 5120,
  parameter int START_PH      = 0,
  parameter int START_PH_INC  = 0,
  parameter int DPH_INC       = -16384,
  parameter int NPH_SHIFT     = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   srst,
  input  logic                   run,
  input  logic [15:0]            amp,
  output logic                   out_tvalid,
  input  logic                   out_tready,
  output logic                   out_tlast,
  output logic                   out_sof,
  output logic [DATA_WIDTH-1:0]  itx,
  output logic [DATA_WIDTH-1:0]  qtx,
  output logic                   busy,
  output logic [PHASE_WIDTH-1:0] ph,
  output logic [PHASE_WIDTH-1:0] sigN,
  output logic [NSYMB_WIDTH-1:0] symbN
);

  localparam logic [PHASE_WIDTH-1:0] c_START_PH  = PHASE_WIDTH'(START_PH);
  localparam logic [PHASE_WIDTH-1:0] c_START_INC = PHASE_WIDTH'(START_PH_INC);
  localparam logic [PHASE_WIDTH-1:0] c_DPH_INC   = PHASE_WIDTH'(DPH_INC);
  localparam logic [PHASE_WIDTH-1:0] c_NPH_SHIFT = PHASE_WIDTH'(NPH_SHIFT);
  localparam logic [PHASE_WIDTH-1:0] c_NSIG      = PHASE_WIDTH'(NSIG);
  localparam logic [PHASE_WIDTH-1:0] c_N_ONE     = PHASE_WIDTH'(1);
  localparam logic [NSYMB_WIDTH-1:0] c_NSYMB     = NSYMB_WIDTH'(NSYMB);
  localparam logic [NSYMB_WIDTH-1:0] c_K_ONE     = NSYMB_WIDTH'(1);
  localparam int                     c_PW        = SIN_COS_WIDTH + 17;

  // Quarter-wave sine, Q1.15, 16 steps per quadrant (64 points per cycle).
  localparam logic signed [15:0] c_QSIN [0:16] = '{
    16'sd0,     16'sd3212,  16'sd6393,  16'sd9512,  16'sd12539, 16'sd15446,
    16'sd18204, 16'sd20787, 16'sd23170, 16'sd25329, 16'sd27245, 16'sd28898,
    16'sd30273, 16'sd31356, 16'sd32137, 16'sd32609, 16'sd32767
  };

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                   w_rst;
  logic                   w_adv;
  logic                   w_start;
  logic                   w_issue;
  logic                   w_last_n;
  logic                   w_last_k;
  logic                   w_frame_end;
  logic                   w_drained;

  logic [PHASE_WIDTH-1:0] r_n;
  logic [NSYMB_WIDTH-1:0] r_k;
  logic [PHASE_WIDTH-1:0] r_ph;
  logic [PHASE_WIDTH-1:0] r_start_ph;
  logic [PHASE_WIDTH-1:0] r_ph_inc;
  logic [15:0]            r_amp;

  logic [1:0]             w_quad;
  logic [3:0]             w_off;
  logic signed [15:0]     w_lo;
  logic signed [15:0]     w_hi;
  logic signed [15:0]     w_sin;
  logic signed [15:0]     w_cos;

  logic                           r_v1;
  logic signed [SIN_COS_WIDTH-1:0] r_cos1;
  logic signed [SIN_COS_WIDTH-1:0] r_sin1;
  logic [15:0]                    r_amp1;
  logic                           r_last1;
  logic                           r_sof1;
  logic [PHASE_WIDTH-1:0]         r_ph1;
  logic [PHASE_WIDTH-1:0]         r_n1;
  logic [NSYMB_WIDTH-1:0]         r_k1;

  logic signed [c_PW-1:0] w_prod_i;
  logic signed [c_PW-1:0] w_prod_q;
  logic                   w_unused;

  logic                   r_v2;
  logic                   r_last2;
  logic                   r_sof2;
  logic [DATA_WIDTH-1:0]  r_itx;
  logic [DATA_WIDTH-1:0]  r_qtx;
  logic [PHASE_WIDTH-1:0] r_ph2;
  logic [PHASE_WIDTH-1:0] r_n2;
  logic [NSYMB_WIDTH-1:0] r_k2;

  assign w_rst       = reset | srst;
  // Whole pipeline moves together; it only freezes when the output is blocked.
  assign w_adv       = !r_v2 || out_tready;
  assign w_start     = (r_state == S_IDLE) && run;
  assign w_issue     = (r_state == S_RUN) && w_adv;
  assign w_last_n    = (r_n == c_NSIG);
  assign w_last_k    = (r_k == c_NSYMB);
  assign w_frame_end = w_issue && w_last_n && w_last_k;
  assign w_drained   = !r_v1 && (!r_v2 || out_tready);

  always_ff @(posedge clk) begin
    if (w_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (run) w_state_nxt = S_RUN;
      S_RUN:   if (w_frame_end && !run) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drained) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Phase schedule: counters step only when a phase word enters the LUT stage.
  always_ff @(posedge clk) begin
    if (w_rst || w_start) begin
      r_n        <= c_N_ONE;
      r_k        <= c_K_ONE;
      r_ph       <= c_START_PH;
      r_start_ph <= c_START_PH;
      r_ph_inc   <= c_START_INC;
      r_amp      <= w_rst ? 16'd0 : amp;
    end else if (w_issue) begin
      if (!w_last_n) begin
        r_n  <= r_n + c_N_ONE;
        r_ph <= r_ph + r_ph_inc;
      end else if (!w_last_k) begin
        r_n        <= c_N_ONE;
        r_k        <= r_k + c_K_ONE;
        r_start_ph <= r_start_ph - c_NPH_SHIFT;
        r_ph       <= r_start_ph - c_NPH_SHIFT;
        r_ph_inc   <= r_ph_inc + c_DPH_INC;
      end else begin
        r_n        <= c_N_ONE;
        r_k        <= c_K_ONE;
        r_ph       <= c_START_PH;
        r_start_ph <= c_START_PH;
        r_ph_inc   <= c_START_INC;
        if (run) r_amp <= amp;
      end
    end
  end

  assign w_quad = r_ph[PHASE_WIDTH-1 -: 2];
  assign w_off  = r_ph[PHASE_WIDTH-3 -: 4];

  always_comb begin
    w_lo  = c_QSIN[{1'b0, w_off}];
    w_hi  = c_QSIN[5'd16 - {1'b0, w_off}];
    w_sin = w_lo;
    w_cos = w_hi;
    case (w_quad)
      2'd1: begin w_sin = w_hi;  w_cos = -w_lo; end
      2'd2: begin w_sin = -w_lo; w_cos = -w_hi; end
      2'd3: begin w_sin = -w_hi; w_cos = w_lo;  end
      default: begin w_sin = w_lo; w_cos = w_hi; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_v1    <= 1'b0;
      r_cos1  <= '0;
      r_sin1  <= '0;
      r_amp1  <= '0;
      r_last1 <= 1'b0;
      r_sof1  <= 1'b0;
      r_ph1   <= c_START_PH;
      r_n1    <= c_N_ONE;
      r_k1    <= c_K_ONE;
    end else if (w_adv) begin
      r_v1 <= w_issue;
      if (w_issue) begin
        r_cos1  <= SIN_COS_WIDTH'(w_cos);
        r_sin1  <= SIN_COS_WIDTH'(w_sin);
        r_amp1  <= r_amp;
        r_last1 <= w_last_n;
        r_sof1  <= (r_n == c_N_ONE) && (r_k == c_K_ONE);
        r_ph1   <= r_ph;
        r_n1    <= r_n;
        r_k1    <= r_k;
      end
    end
  end

  // Amplitude is unsigned: widen with a zero MSB before the signed multiply.
  assign w_prod_i = c_PW'(r_cos1) * c_PW'($signed({1'b0, r_amp1}));
  assign w_prod_q = c_PW'(r_sin1) * c_PW'($signed({1'b0, r_amp1}));
  assign w_unused = ^{w_prod_i[15:0], w_prod_i[c_PW-1:16+DATA_WIDTH],
                      w_prod_q[15:0], w_prod_q[c_PW-1:16+DATA_WIDTH]};

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_v2    <= 1'b0;
      r_last2 <= 1'b0;
      r_sof2  <= 1'b0;
      r_itx   <= '0;
      r_qtx   <= '0;
      r_ph2   <= c_START_PH;
      r_n2    <= c_N_ONE;
      r_k2    <= c_K_ONE;
    end else if (w_adv) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_last2 <= r_last1;
        r_sof2  <= r_sof1;
        r_itx   <= w_prod_i[16 +: DATA_WIDTH];
        r_qtx   <= w_prod_q[16 +: DATA_WIDTH];
        r_ph2   <= r_ph1;
        r_n2    <= r_n1;
        r_k2    <= r_k1;
      end else begin
        r_last2 <= 1'b0;
        r_sof2  <= 1'b0;
      end
    end
  end

  // Debug indices follow the sample currently presented at the output.
  assign out_tvalid = r_v2;
  assign out_tlast  = r_last2;
  assign out_sof    = r_sof2;
  assign itx        = r_itx;
  assign qtx        = r_qtx;
  assign ph         = r_ph2;
  assign sigN       = r_n2;
  assign symbN      = r_k2;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tag_tx.sv
`default_nettype none
// Bench for tag_tx: closed-form phase/IQ scoreboard, amplitude vector table,
// and directed stall / stop / soft-reset / phase-wrap sequences.
module tb_tag_tx;

  localparam int NSIG   = 4;
  localparam int NSYMB  = 3;
  localparam int FRAME  = NSIG * NSYMB;
  localparam int PH_INC = 32'h010000;
  localparam int DPH    = 32'h010000;
  localparam int NPH6   = 32'h001000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, srst, run, out_tready;
  logic [15:0] amp;
  logic        out_tvalid, out_tlast, out_sof, busy;
  logic [15:0] itx, qtx, symbN;
  logic [23:0] ph, sigN;

  logic        srst6, run6, out_tready6;
  logic [15:0] amp6;
  logic        out_tvalid6, out_tlast6, out_sof6, busy6;
  logic [15:0] itx6, qtx6, symbN6;
  logic [23:0] ph6, sigN6;

  tag_tx #(.NSIG(NSIG), .NSYMB(NSYMB), .START_PH(0), .START_PH_INC(PH_INC),
           .DPH_INC(DPH), .NPH_SHIFT(0)) u_dut (
    .clk(clk), .reset(reset), .srst(srst), .run(run), .amp(amp),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .out_sof(out_sof), .itx(itx), .qtx(qtx), .busy(busy), .ph(ph),
    .sigN(sigN), .symbN(symbN));

  tag_tx #(.NSIG(NSIG), .NSYMB(NSYMB), .START_PH(0), .START_PH_INC(PH_INC),
           .DPH_INC(DPH), .NPH_SHIFT(NPH6)) u_dut6 (
    .clk(clk), .reset(reset), .srst(srst6), .run(run6), .amp(amp6),
    .out_tvalid(out_tvalid6), .out_tready(out_tready6), .out_tlast(out_tlast6),
    .out_sof(out_sof6), .itx(itx6), .qtx(qtx6), .busy(busy6), .ph(ph6),
    .sigN(sigN6), .symbN(symbN6));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_tol(input string name, input longint act, input longint exp, input longint tol);
    n_tests++;
    if (act > exp + tol || act < exp - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // Phase of zero-based sample idx within a frame, straight from the schedule formula.
  function automatic logic [23:0] exp_ph(input int idx, input int nph);
    longint n, k, p;
    n = longint'(idx % NSIG);
    k = longint'(idx / NSIG);
    p = 0 - k * longint'(nph) + n * (longint'(PH_INC) + k * longint'(DPH));
    return p[23:0];
  endfunction

  // Ideal 64-point sine/cosine of the phase, scaled by amp and shifted right 16.
  function automatic int exp_iq(input logic [23:0] p, input logic [15:0] a, input bit use_sin);
    real    ang;
    int     lut;
    longint prod;
    ang  = 6.283185307179586 * real'(p[23:18]) / 64.0;
    lut  = use_sin ? int'(32767.0 * $sin(ang)) : int'(32767.0 * $cos(ang));
    prod = longint'(lut) * longint'({48'd0, a});
    return int'(prod >>> 16);
  endfunction

  // ---------------- scoreboard for u_dut ----------------
  int          exp_idx = 0;
  int          acc_cnt = 0;
  int          mi, mf;
  logic [15:0] amp_fr [0:3];
  bit          mon_hold = 1'b0;
  logic [34:0] hold_snap;
  logic [23:0] mph;

  always @(negedge clk) begin
    if (mon_hold)
      chk("hold", {out_tvalid, itx, qtx, out_tlast, out_sof}, hold_snap);
    mon_hold  = out_tvalid && !out_tready && !reset && !srst;
    hold_snap = {out_tvalid, itx, qtx, out_tlast, out_sof};
    if (out_tvalid && out_tready) begin
      mi  = exp_idx % FRAME;
      mf  = (exp_idx / FRAME > 3) ? 3 : exp_idx / FRAME;
      mph = exp_ph(mi, 0);
      chk("ph", ph, mph);
      chk("sigN", sigN, mi % NSIG + 1);
      chk("symbN", symbN, mi / NSIG + 1);
      chk("tlast", out_tlast, longint'((mi % NSIG) == NSIG - 1));
      chk("sof", out_sof, longint'(mi == 0));
      chk("busy_on_accept", busy, 1);
      chk_tol("itx", $signed(itx), exp_iq(mph, amp_fr[mf], 1'b0), 2);
      chk_tol("qtx", $signed(qtx), exp_iq(mph, amp_fr[mf], 1'b1), 2);
      exp_idx++;
      acc_cnt++;
    end
  end

  // ---------------- scoreboard for u_dut6 (start-phase shift) ----------------
  int          acc6 = 0;
  int          mi6;
  logic [23:0] sp6 [0:2];
  logic [23:0] mph6;

  always @(negedge clk) begin
    if (out_tvalid6 && out_tready6) begin
      mi6  = acc6 % FRAME;
      mph6 = exp_ph(mi6, NPH6);
      chk("ph6", ph6, mph6);
      chk("tlast6", out_tlast6, longint'((mi6 % NSIG) == NSIG - 1));
      chk("sof6", out_sof6, longint'(mi6 == 0));
      chk_tol("itx6", $signed(itx6), exp_iq(mph6, amp6, 1'b0), 2);
      chk_tol("qtx6", $signed(qtx6), exp_iq(mph6, amp6, 1'b1), 2);
      if (sigN6 == 24'd1 && symbN6 >= 16'd1 && symbN6 <= 16'd3)
        sp6[symbN6 - 16'd1] = ph6;
      acc6++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target, input int budget);
    int c = 0;
    while (acc_cnt < target && c < budget) begin tick(); c++; end
    chk("acc_timeout", longint'(acc_cnt >= target), 1);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (busy && c < budget) begin tick(); c++; end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic set_amp(input logic [15:0] a);
    amp = a;
    for (int i = 0; i < 4; i++) amp_fr[i] = a;
  endtask

  task automatic new_frame();
    exp_idx = 0;
    acc_cnt = 0;
  endtask

  typedef struct {
    logic [15:0] a;
    int          exp_i;
    int          exp_q;
  } amp_vec_t;

  amp_vec_t vecs [0:5];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int nv;

    vecs[0] = '{16'hFFFF, 32766, 0};
    vecs[1] = '{16'h8000, 16383, 0};
    vecs[2] = '{16'h4000, 8191,  0};
    vecs[3] = '{16'hC000, 24575, 0};
    vecs[4] = '{16'h0001, 0,     0};
    vecs[5] = '{16'h0000, 0,     0};

    reset = 1'b1; srst = 1'b0; run = 1'b0; out_tready = 1'b1;
    srst6 = 1'b0; run6 = 1'b0; out_tready6 = 1'b1; amp6 = 16'hFFFF;
    set_amp(16'hFFFF);
    repeat (3) tick();

    // Reset state
    chk("rst_tvalid", out_tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tlast", out_tlast, 0);
    chk("rst_sof", out_sof, 0);
    chk("rst_itx", itx, 0);
    chk("rst_qtx", qtx, 0);
    chk("rst_ph", ph, 0);
    chk("rst_sigN", sigN, 1);
    chk("rst_symbN", symbN, 1);
    reset = 1'b0;
    tick();

    // Full frame at full throughput; latency from run to first valid
    new_frame();
    run = 1'b1;
    c = 0;
    while (!out_tvalid && c < 20) begin tick(); c++; end
    chk("latency_le_8", longint'(c <= 8), 1);
    wait_acc(1, 20);
    run = 1'b0;
    wait_idle(100);
    chk("s1_count", acc_cnt, FRAME);

    // Amplitude table: first sample has phase 0, so I = 32767*amp>>>16, Q = 0
    nv = 0;
    foreach (vecs[v]) begin
      set_amp(vecs[v].a);
      new_frame();
      run = 1'b1;
      c = 0;
      while (!out_tvalid && c < 20) begin tick(); c++; end
      chk("vec_valid", out_tvalid, 1);
      chk("vec_itx", $signed(itx), vecs[v].exp_i);
      chk("vec_qtx", $signed(qtx), vecs[v].exp_q);
      run = 1'b0;
      wait_idle(100);
      nv++;
    end
    chk("vec_all_run", nv, 6);

    // Random backpressure across three back-to-back frames; amp change lands on frame 3
    set_amp(16'hFFFF);
    amp_fr[2] = 16'h8000;
    amp_fr[3] = 16'h8000;
    new_frame();
    run = 1'b1;
    c = 0;
    while (acc_cnt < 25 && c < 600) begin
      if (acc_cnt >= 14) amp = 16'h8000;
      out_tready = 1'($urandom_range(0, 1));
      tick();
      c++;
    end
    run = 1'b0;
    c = 0;
    while (busy && c < 600) begin
      out_tready = 1'($urandom_range(0, 1));
      tick();
      c++;
    end
    out_tready = 1'b1;
    chk("s3_idle", busy, 0);
    chk("s3_count", acc_cnt, 3 * FRAME);

    // run dropped at sample 5: frame still completes, then nothing more
    set_amp(16'h8000);
    new_frame();
    run = 1'b1;
    wait_acc(4, 40);
    run = 1'b0;
    wait_acc(FRAME, 60);
    chk("s4_busy_after_last", busy, 0);
    chk("s4_count", acc_cnt, FRAME);
    c = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_tvalid) c++;
      tick();
    end
    chk("s4_no_tvalid", c, 0);

    // srst while stalled on sample 6
    set_amp(16'hFFFF);
    new_frame();
    run = 1'b1;
    wait_acc(5, 40);
    out_tready = 1'b0;
    tick();
    tick();
    chk("s5_stalled_valid", out_tvalid, 1);
    run  = 1'b0;
    srst = 1'b1;
    tick();
    srst = 1'b0;
    chk("s5_tvalid", out_tvalid, 0);
    chk("s5_busy", busy, 0);
    chk("s5_ph", ph, 0);
    chk("s5_sigN", sigN, 1);
    chk("s5_itx", itx, 0);
    tick();
    out_tready = 1'b1;
    new_frame();
    run = 1'b1;
    wait_acc(1, 20);
    run = 1'b0;
    wait_idle(100);
    chk("s5_count", acc_cnt, FRAME);

    // Start-phase decrement wraps below zero
    run6 = 1'b1;
    c = 0;
    while (acc6 < 1 && c < 20) begin tick(); c++; end
    run6 = 1'b0;
    c = 0;
    while (busy6 && c < 100) begin tick(); c++; end
    chk("s6_idle", busy6, 0);
    chk("s6_count", acc6, FRAME);
    chk("s6_sp1", sp6[0], 24'h000000);
    chk("s6_sp2", sp6[1], 24'hFFF000);
    chk("s6_sp3", sp6[2], 24'hFFE000);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
